// File: rtl/led_mode_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// led_mode_ctrl : pushbutton-selected LED mode controller (OFF/SLOW/FAST/HEART/ON)
// Revision 1.0
// ============================================================================
module led_mode_ctrl #(
    parameter int TICK_DIV     = 50000,
    parameter int DEBOUNCE_MS  = 20,
    parameter int SLOW_HALF_MS = 500,
    parameter int FAST_HALF_MS = 250
) (
    input  logic       CLK50,
    input  logic       RESET_N,
    input  logic       BTN,
    output logic       LED,
    output logic [2:0] MODE
);

    typedef enum logic [2:0] {
        MODE_OFF   = 3'd0,
        MODE_SLOW  = 3'd1,
        MODE_FAST  = 3'd2,
        MODE_HEART = 3'd3,
        MODE_ON    = 3'd4
    } mode_t;

    localparam logic [19:0] PRE_LAST   = 20'(TICK_DIV - 1);
    localparam logic [7:0]  DB_LAST    = 8'(DEBOUNCE_MS - 1);
    localparam logic [15:0] SLOW_LAST  = 16'(SLOW_HALF_MS - 1);
    localparam logic [15:0] FAST_LAST  = 16'(FAST_HALF_MS - 1);
    localparam logic [15:0] HEART_LAST = 16'd999;

    logic        sync_meta;
    logic        btn_s;
    logic        sync_ok1;
    logic        sync_ok2;
    logic        armed;
    logic [19:0] pre_cnt;
    logic        tick;
    logic [7:0]  db_cnt;
    logic        db_level;
    logic        db_accept;
    logic        press;
    mode_t       state;
    mode_t       state_nx;
    logic [15:0] phase;
    logic [15:0] phase_nx;
    logic [15:0] phase_inc;
    logic [15:0] blink_last;
    logic        led;
    logic        led_nx;

    // A press is only honoured once the synchronized button has been seen
    // low after reset, so a button held through reset never steps the mode.
    always_ff @(posedge CLK50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_meta <= 1'b0;
            btn_s     <= 1'b0;
            sync_ok1  <= 1'b0;
            sync_ok2  <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sync_meta <= BTN;
            btn_s     <= sync_meta;
            sync_ok1  <= 1'b1;
            sync_ok2  <= sync_ok1;
            if (sync_ok2 && !btn_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge CLK50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pre_cnt <= 20'd0;
        end else if (tick) begin
            pre_cnt <= 20'd0;
        end else begin
            pre_cnt <= pre_cnt + 20'd1;
        end
    end

    assign db_accept = tick && (btn_s != db_level) && (db_cnt == DB_LAST);
    assign press     = db_accept && btn_s && armed;

    always_ff @(posedge CLK50 or negedge RESET_N) begin
        if (!RESET_N) begin
            db_cnt   <= 8'd0;
            db_level <= 1'b0;
        end else if (tick) begin
            if (btn_s == db_level) begin
                db_cnt <= 8'd0;
            end else if (db_accept) begin
                db_level <= btn_s;
                db_cnt   <= 8'd0;
            end else begin
                db_cnt <= db_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= MODE_OFF;
            phase <= 16'd0;
            led   <= 1'b0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            led   <= led_nx;
        end
    end

    // A press always lands on a tick; the mode change takes priority over
    // any blink update due on that tick.
    always_comb begin
        state_nx   = state;
        phase_nx   = phase;
        led_nx     = led;
        phase_inc  = phase + 16'd1;
        blink_last = (state == MODE_SLOW) ? SLOW_LAST : FAST_LAST;
        case (state)
            MODE_OFF: begin
                phase_nx = 16'd0;
                led_nx   = 1'b0;
                if (press) begin
                    state_nx = MODE_SLOW;
                    led_nx   = 1'b1;
                end
            end
            MODE_SLOW, MODE_FAST: begin
                if (press) begin
                    state_nx = (state == MODE_SLOW) ? MODE_FAST : MODE_HEART;
                    phase_nx = 16'd0;
                    led_nx   = 1'b1;
                end else if (tick) begin
                    if (phase == blink_last) begin
                        phase_nx = 16'd0;
                        led_nx   = ~led;
                    end else begin
                        phase_nx = phase_inc;
                    end
                end
            end
            MODE_HEART: begin
                if (press) begin
                    state_nx = MODE_ON;
                    phase_nx = 16'd0;
                    led_nx   = 1'b1;
                end else if (tick) begin
                    phase_nx = (phase == HEART_LAST) ? 16'd0 : phase_inc;
                    led_nx   = (phase_nx < 16'd100) ||
                               ((phase_nx >= 16'd200) && (phase_nx < 16'd300));
                end
            end
            MODE_ON: begin
                phase_nx = 16'd0;
                led_nx   = 1'b1;
                if (press) begin
                    state_nx = MODE_OFF;
                    led_nx   = 1'b0;
                end
            end
            default: begin
                state_nx = MODE_OFF;
                phase_nx = 16'd0;
                led_nx   = 1'b0;
            end
        endcase
    end

    assign LED  = led;
    assign MODE = state;

endmodule
`default_nettype wire
